// File: rtl/mux_bus4.sv
// Registered N-to-1 lane multiplexer: picks one WIDTH-bit lane from a packed bus
// and registers it, flagging select codes that point past the last lane.
module mux_bus4 #(
  parameter int WIDTH = 4,
  parameter int N     = 8,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:N*WIDTH-1]     in,
  input  logic [0:SEL_W-1]       sel,
  input  logic                   valid_in,
  output logic [0:WIDTH-1]       out,
  output logic                   valid_out,
  output logic                   sel_err
);

  // valid_in qualifies in/sel for one cycle; there is no ready. valid_out pulses
  // one clock later for every accepted cycle, so a new select may issue each clock.
  localparam logic [SEL_W:0] NUM_LANES = N[SEL_W:0];

  logic [SEL_W:0]   sel_ext;
  logic             sel_in_range;
  logic [0:WIDTH-1] lane_sel;

  logic [0:WIDTH-1] out_q, out_d;
  logic             err_q, err_d;
  logic             valid_q;

  assign sel_ext      = {1'b0, sel};
  assign sel_in_range = (sel_ext < NUM_LANES);

  // Decoded compare per lane keeps the part-select index in range for any sel.
  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_ext == k[SEL_W:0]) lane_sel = in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (valid_in) begin
      out_d = sel_in_range ? lane_sel : '0;
      err_d = ~sel_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      err_q   <= err_d;
      valid_q <= valid_in;
    end
  end

  assign out       = out_q;
  assign sel_err   = err_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_bus4.sv
// Self-checking bench for mux_bus4: directed vector table plus a randomized
// phase checked against a small reference model through an expected queue.
module tb_mux_bus4;

  logic        clk;
  logic        reset;
  logic [0:31] in_bus;
  logic [0:3]  sel;
  logic        valid_in;
  logic [0:3]  out;
  logic        valid_out;
  logic        sel_err;

  mux_bus4 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_bus),
    .sel       (sel),
    .valid_in  (valid_in),
    .out       (out),
    .valid_out (valid_out),
    .sel_err   (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        vin;
    logic [3:0]  sel;
    logic [31:0] lanes;
    logic [3:0]  exp_out;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         tests_run;
  int         tests_failed;

  // reference model state for the random phase
  logic [3:0] m_out;
  logic       m_err;

  function automatic vec_t mk(input logic rst, input logic vin, input logic [3:0] s,
                              input logic [31:0] lanes, input logic [3:0] eo,
                              input logic ev, input logic ee);
    vec_t v;
    v.rst = rst; v.vin = vin; v.sel = s; v.lanes = lanes;
    v.exp_out = eo; v.exp_vld = ev; v.exp_err = ee;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, then compare just after the edge.
  task automatic step(input logic rst, input logic vin, input logic [3:0] s,
                      input logic [31:0] lanes, input logic [5:0] expv, input string name);
    logic [5:0] e;
    logic [5:0] act;
    reset    = rst;
    valid_in = vin;
    sel      = s;
    in_bus   = lanes;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    act = {valid_out, sel_err, out};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, got vld/err/out=%b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        tests_failed++;
        $display("FAIL %s: got vld=%b err=%b out=%0d, expected vld=%b err=%b out=%0d",
                 name, act[5], act[4], act[3:0], e[5], e[4], e[3:0]);
      end
    end
  endtask

  initial begin
    logic [31:0] lanes;
    logic [31:0] l_test;
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    sel      = '0;
    in_bus   = '0;

    // lanes 0..7 = 12,15,1,3,5,2,11,14 (lane 0 in the top nibble)
    l_test = 32'hCF13_52BE;

    vecs.push_back(mk(1, 1, 4'd3,  l_test, 4'd0,  0, 0));
    vecs.push_back(mk(1, 1, 4'd3,  l_test, 4'd0,  0, 0));
    vecs.push_back(mk(0, 0, 4'd3,  l_test, 4'd0,  0, 0));
    vecs.push_back(mk(0, 1, 4'd3,  l_test, 4'd3,  1, 0));
    vecs.push_back(mk(0, 1, 4'd5,  l_test, 4'd2,  1, 0));
    vecs.push_back(mk(0, 1, 4'd7,  l_test, 4'd14, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0,  l_test, 4'd12, 1, 0));
    vecs.push_back(mk(0, 1, 4'd2,  l_test, 4'd1,  1, 0));
    vecs.push_back(mk(0, 1, 4'd8,  l_test, 4'd0,  1, 1));
    vecs.push_back(mk(0, 1, 4'd15, l_test, 4'd0,  1, 1));
    vecs.push_back(mk(0, 0, 4'd2,  l_test, 4'd0,  0, 1));
    vecs.push_back(mk(0, 1, 4'd1,  l_test, 4'd15, 1, 0));
    vecs.push_back(mk(0, 1, 4'd6,  l_test, 4'd11, 1, 0));
    vecs.push_back(mk(0, 0, 4'd1,  32'hCF13_529E, 4'd11, 0, 0));
    vecs.push_back(mk(0, 0, 4'd6,  32'hCF13_529E, 4'd11, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0,  l_test, 4'd12, 1, 0));
    vecs.push_back(mk(0, 1, 4'd1,  l_test, 4'd15, 1, 0));
    vecs.push_back(mk(1, 1, 4'd2,  l_test, 4'd0,  0, 0));
    vecs.push_back(mk(0, 1, 4'd4,  l_test, 4'd5,  1, 0));
    vecs.push_back(mk(0, 1, 4'd7,  32'h0000_0008, 4'd8, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0,  32'h1000_0000, 4'd1, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0,  32'h8000_0000, 4'd8, 1, 0));
    vecs.push_back(mk(0, 1, 4'd7,  32'h0000_0001, 4'd1, 1, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vin, vecs[i].sel, vecs[i].lanes,
           {vecs[i].exp_vld, vecs[i].exp_err, vecs[i].exp_out},
           $sformatf("vec%0d", i));
    end

    // Random phase: model tracks held out/err across idle and reset cycles.
    m_out = 4'd1;
    m_err = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic       r_rst;
      logic       r_vin;
      logic [3:0] r_sel;
      logic       e_vld;
      lanes = $urandom;
      r_rst = ($urandom_range(0, 19) == 0);
      r_vin = ($urandom_range(0, 3) != 0);
      r_sel = 4'($urandom_range(0, 15));
      e_vld = 1'b0;
      if (r_rst) begin
        m_out = '0;
        m_err = 1'b0;
      end else if (r_vin) begin
        e_vld = 1'b1;
        if (r_sel < 4'd8) begin
          m_out = lanes[31 - 4*r_sel -: 4];
          m_err = 1'b0;
        end else begin
          m_out = '0;
          m_err = 1'b1;
        end
      end
      step(r_rst, r_vin, r_sel, lanes, {e_vld, m_err, m_out}, $sformatf("rand%0d", n));
    end

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
